// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner slice: calculator key codes
// and the scanner state encoding.
package keypad_pkg;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_ADD  = 4'hA;
   localparam logic [3:0] KEY_SUB  = 4'hB;
   localparam logic [3:0] KEY_EQ   = 4'hC;
   localparam logic [3:0] KEY_NONE = 4'hD;
   localparam logic [3:0] KEY_CLR  = 4'hF;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/keypad_map.sv
// Combinational translation of a 4x4 key index (col_idx*4 + row_idx)
// into the calculator core's 4-bit key code.
module keypad_map
   import keypad_pkg::*;
(
   input  logic [3:0] key_idx,
   output logic [3:0] code_c
);

   // Columns left to right: 1-4-7-C, 2-5-8-0, 3-6-9-=, +/- with two blanks.
   always_comb begin
      code_c = KEY_NONE;
      case (key_idx)
         4'd0:    code_c = KEY_1;
         4'd1:    code_c = KEY_4;
         4'd2:    code_c = KEY_7;
         4'd3:    code_c = KEY_CLR;
         4'd4:    code_c = KEY_2;
         4'd5:    code_c = KEY_5;
         4'd6:    code_c = KEY_8;
         4'd7:    code_c = KEY_0;
         4'd8:    code_c = KEY_3;
         4'd9:    code_c = KEY_6;
         4'd10:   code_c = KEY_9;
         4'd11:   code_c = KEY_EQ;
         4'd12:   code_c = KEY_ADD;
         4'd13:   code_c = KEY_SUB;
         default: code_c = KEY_NONE;
      endcase
   end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing matrix keypad scanner with press/release debounce,
// ghost rejection and optional auto-repeat of a held key.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter  int unsigned ROWS           = 4,
   parameter  int unsigned COLS           = 4,
   parameter  int unsigned SCAN_DIV       = 100000,
   parameter  int unsigned SETTLE         = 10,
   parameter  int unsigned DEBOUNCE_SCANS = 3,
   parameter  int unsigned REPEAT_SCANS   = 0,
   localparam int unsigned KEYW           = $clog2(ROWS*COLS)
)(
   input  logic            CLK2MHZ,
   input  logic            RST,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [KEYW-1:0] key_idx,
   output logic            key_valid,
   output logic            key_held,
   output logic            ghost
);

   localparam int unsigned CNTW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned COLW    = $clog2(COLS);
   localparam int unsigned ROWW    = $clog2(ROWS);
   localparam int unsigned SUB_MAX = max_u(DEBOUNCE_SCANS, REPEAT_SCANS) + 1;
   localparam int unsigned SUBW    = $clog2(SUB_MAX + 1);

   state_t          state, state_nx;
   logic [ROWS-1:0] row_s1, row_s2;
   logic [CNTW-1:0] cnt, cnt_nx;
   logic [COLW-1:0] col_idx, col_idx_nx;
   logic [COLS-1:0] col_nx;
   logic [KEYW-1:0] cand_idx, cand_nx, key_idx_nx, hit_idx;
   logic [SUBW-1:0] deb, deb_nx, rel, rel_nx, rep, rep_nx;
   logic            valid_nx, ghost_nx;
   logic [ROWS-1:0] low;
   logic [ROWW-1:0] row_j;
   logic            one_low, multi_low, sample, wrap;

   // Decode the synchronised row sample into "none / exactly one / several".
   always_comb begin
      low       = ~row_s2;
      one_low   = (low != '0) && ((low & (low - ROWS'(1))) == '0);
      multi_low = (low != '0) && !one_low;
      row_j     = '0;
      for (int unsigned j = 0; j < ROWS; j++) begin
         if (low[ROWS-1-j]) row_j = ROWW'(j);
      end
      hit_idx = KEYW'(32'(col_idx) * ROWS + 32'(row_j));
      sample  = (cnt == CNTW'(SETTLE));
      wrap    = (cnt == CNTW'(SCAN_DIV - 1));
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = wrap ? '0 : cnt + CNTW'(1);
      col_idx_nx = col_idx;
      cand_nx    = cand_idx;
      key_idx_nx = key_idx;
      deb_nx     = deb;
      rel_nx     = rel;
      rep_nx     = rep;
      valid_nx   = 1'b0;
      ghost_nx   = 1'b0;

      // The strobe only walks while searching; a candidate or held key freezes it.
      if (wrap && state == SCAN)
         col_idx_nx = (col_idx == COLW'(COLS - 1)) ? '0 : col_idx + COLW'(1);

      if (sample) begin
         ghost_nx = multi_low;
         case (state)
            SCAN: begin
               if (one_low) begin
                  cand_nx = hit_idx;
                  if (DEBOUNCE_SCANS == 1) begin
                     key_idx_nx = hit_idx;
                     valid_nx   = 1'b1;
                     rep_nx     = '0;
                     deb_nx     = '0;
                     state_nx   = HELD;
                  end else begin
                     deb_nx   = SUBW'(1);
                     state_nx = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (one_low && hit_idx == cand_idx) begin
                  if (deb + SUBW'(1) == SUBW'(DEBOUNCE_SCANS)) begin
                     key_idx_nx = cand_idx;
                     valid_nx   = 1'b1;
                     rep_nx     = '0;
                     deb_nx     = '0;
                     state_nx   = HELD;
                  end else begin
                     deb_nx = deb + SUBW'(1);
                  end
               end else begin
                  deb_nx   = '0;
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (low == '0) begin
                  if (rel + SUBW'(1) == SUBW'(DEBOUNCE_SCANS)) begin
                     rel_nx   = '0;
                     state_nx = SCAN;
                  end else begin
                     rel_nx = rel + SUBW'(1);
                  end
               end else begin
                  rel_nx = '0;
               end
               if (REPEAT_SCANS > 0 && one_low && hit_idx == key_idx) begin
                  if (rep + SUBW'(1) == SUBW'(REPEAT_SCANS)) begin
                     rep_nx   = '0;
                     valid_nx = 1'b1;
                  end else begin
                     rep_nx = rep + SUBW'(1);
                  end
               end
            end
            default: state_nx = SCAN;
         endcase
      end

      col_nx = ~(COLS'(1) << (COLW'(COLS - 1) - col_idx_nx));
   end

   always_ff @(posedge CLK2MHZ) begin
      if (RST) begin
         state     <= SCAN;
         row_s1    <= '1;
         row_s2    <= '1;
         cnt       <= '0;
         col_idx   <= '0;
         col       <= {1'b0, {(COLS-1){1'b1}}};
         cand_idx  <= '0;
         key_idx   <= '0;
         deb       <= '0;
         rel       <= '0;
         rep       <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         ghost     <= 1'b0;
      end else begin
         state     <= state_nx;
         row_s1    <= row;
         row_s2    <= row_s1;
         cnt       <= cnt_nx;
         col_idx   <= col_idx_nx;
         col       <= col_nx;
         cand_idx  <= cand_nx;
         key_idx   <= key_idx_nx;
         deb       <= deb_nx;
         rel       <= rel_nx;
         rep       <= rep_nx;
         key_valid <= valid_nx;
         key_held  <= (state_nx == HELD);
         ghost     <= ghost_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a simulated key matrix drives the rows,
// a slot-level model predicts key/ghost events, a monitor checks them.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SD  = 16;
   localparam int ST  = 2;
   localparam int DEB = 3;
   localparam int REP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row, col, key_idx, code, map_idx;
   logic       key_valid, key_held, ghost;

   always #5 clk = ~clk;

   keypad_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(SD), .SETTLE(ST),
      .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)
   ) dut (
      .CLK2MHZ(clk), .RST(rst), .row(row), .col(col), .key_idx(key_idx),
      .key_valid(key_valid), .key_held(key_held), .ghost(ghost)
   );

   keypad_map umap (.key_idx(map_idx), .code_c(code));

   typedef struct {
      bit is_ghost;
      int idx;
      int due;
   } exp_t;

   exp_t        sbq[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   bit   [15:0] pressed;   // pressed[k*4+j]: key at column k, row j

   // Model state: 0 searching, 1 confirming a candidate, 2 key held.
   int m_cnt, m_col, m_state, m_cand, m_deb, m_rel, m_rep, m_key;

   always @(posedge clk) cyc <= cyc + 1;

   // Physical matrix: a pressed key shorts its row to its column strobe.
   always_comb begin
      row = 4'hF;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            if (col[3-k] == 1'b0 && pressed[k*4+j]) row[3-j] = 1'b0;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every pulse on the outputs must match the oldest prediction.
   always @(negedge clk) begin
      if (key_valid || ghost) begin
         exp_t e;
         if (key_valid && ghost) check("valid_ghost_overlap", 1, 0);
         if (sbq.size() == 0) begin
            check("unexpected_event", key_valid ? 1 : 2, 0);
         end else begin
            e = sbq.pop_front();
            check("event_is_ghost", int'(ghost), int'(e.is_ghost));
            check("event_cycle", cyc, e.due);
            if (!e.is_ghost) check("event_key_idx", int'(key_idx), e.idx);
         end
      end
   end

   task automatic model_reset();
      m_cnt = 0; m_col = 0; m_state = 0; m_cand = 0;
      m_deb = 0; m_rel = 0; m_rep = 0; m_key = 0;
   endtask

   task automatic push_event(input bit g, input int idx);
      exp_t e;
      e.is_ghost = g;
      e.idx      = idx;
      e.due      = cyc + 1;
      sbq.push_back(e);
   endtask

   task automatic accept(input int idx);
      push_event(1'b0, idx);
      m_key = idx; m_rep = 0; m_deb = 0; m_state = 2;
   endtask

   // One scan sample: which keys of the strobed column are down, and what that means.
   task automatic model_sample();
      int rows[$];
      int n, idx;
      for (int j = 0; j < 4; j++) if (pressed[m_col*4+j]) rows.push_back(j);
      n   = rows.size();
      idx = (n == 1) ? m_col * 4 + rows[0] : -1;
      if (n >= 2) push_event(1'b1, 0);
      case (m_state)
         0: if (n == 1) begin
               m_cand = idx; m_deb = 1; m_state = 1;
               if (DEB == 1) accept(idx);
            end
         1: if (n == 1 && idx == m_cand) begin
               m_deb++;
               if (m_deb == DEB) accept(m_cand);
            end else begin
               m_deb = 0; m_state = 0;
            end
         default: begin
            if (n == 0) begin
               m_rel++;
               if (m_rel == DEB) begin m_rel = 0; m_state = 0; end
            end else begin
               m_rel = 0;
            end
            if (REP > 0 && n == 1 && idx == m_key) begin
               m_rep++;
               if (m_rep == REP) begin m_rep = 0; push_event(1'b0, m_key); end
            end
         end
      endcase
   endtask

   task automatic step();
      logic [3:0] ec;
      if (m_cnt == ST) model_sample();
      if (m_cnt == 5) begin
         ec = 4'hF;
         ec[3-m_col] = 1'b0;
         check("col", int'(col), int'(ec));
         check("key_held", int'(key_held), int'(m_state == 2));
         check("key_idx", int'(key_idx), m_key);
      end
      if (m_cnt == SD - 1 && m_state == 0) m_col = (m_col + 1) % 4;
      m_cnt = (m_cnt + 1) % SD;
      @(negedge clk);
   endtask

   task automatic run_slots(input int n);
      repeat (n * SD) step();
   endtask

   task automatic to_mid();
      while (m_cnt != 8) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      check("rst_col", int'(col), 4'b0111);
      check("rst_key_held", int'(key_held), 0);
      check("rst_key_idx", int'(key_idx), 0);
      check("rst_key_valid", int'(key_valid), 0);
      check("rst_ghost", int'(ghost), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   int exp_code[16] = '{1, 4, 7, 15, 2, 5, 8, 0, 3, 6, 9, 12, 10, 11, 13, 13};

   initial begin
      rst     = 1'b1;
      pressed = '0;
      map_idx = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Idle scanning.
      run_slots(5);
      to_mid();

      // Single key at column 2, row 1: press, hold, release.
      pressed = 16'h0001 << 9;
      run_slots(6);
      pressed = '0;
      run_slots(6);

      // Bounce: 1 slot down, 1 up, 1 down.
      pressed = 16'h0001 << 5;
      run_slots(1);
      pressed = '0;
      run_slots(1);
      pressed = 16'h0001 << 5;
      run_slots(1);
      pressed = '0;
      run_slots(4);

      // Two keys in column 0 (rows 0 and 1): ghost, no key.
      pressed = 16'h0003;
      run_slots(5);
      pressed = '0;
      run_slots(2);

      // Long hold for auto-repeat.
      pressed = 16'h0001 << 15;
      run_slots(20);
      pressed = '0;
      run_slots(5);

      // Reset while a key is held, key stays pressed through and after reset.
      pressed = 16'h0001 << 9;
      run_slots(8);
      check("held_before_reset", int'(key_held), 1);
      do_reset();
      run_slots(8);
      pressed = '0;
      run_slots(5);

      // Randomised key activity.
      for (int it = 0; it < 120; it++) begin
         int r, k;
         r = int'($urandom_range(0, 9));
         to_mid();
         if (r < 4) begin
            pressed = '0;
         end else if (r < 8) begin
            pressed = 16'h0001 << $urandom_range(0, 15);
         end else if (r == 8) begin
            k = int'($urandom_range(0, 3));
            pressed = (16'h0001 << (k*4 + int'($urandom_range(0, 1))))
                    | (16'h0001 << (k*4 + int'($urandom_range(2, 3))));
         end else begin
            pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         end
         run_slots(int'($urandom_range(1, 6)));
      end
      pressed = '0;
      run_slots(6);
      check("scoreboard_drained", sbq.size(), 0);

      // Key code lookup.
      for (int i = 0; i < 16; i++) begin
         map_idx = 4'(i);
         #1;
         check("map_code", int'(code), exp_code[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
